// File: rtl/uart_frame_pkg.sv
// Shared types and helpers for the framed UART byte-stream codec.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    R_HUNT,
    R_DATA,
    R_CHK,
    R_DONE
  } rx_state_t;

  typedef enum logic [2:0] {
    T_IDLE,
    T_SOF,
    T_DATA,
    T_CHK,
    T_GAP
  } tx_state_t;

  localparam logic [1:0] CODE_CHECKSUM = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT  = 2'b10;

  // Number of whole bytes needed to carry a word of the given width.
  function automatic int ceil_div(input int width, input int size);
    return (width + size - 1) / size;
  endfunction

endpackage

// File: rtl/uart_frame_ser.sv
// TX serializer: turns one wide word into SOF, payload (MSB byte first)
// and an optional additive checksum byte, paced by the UART_TX handshake.
module uart_frame_ser
  import uart_frame_pkg::*;
#(
  parameter int                   DATA_SIZE   = 8,
  parameter int                   TX_WIDTH    = 38,
  parameter logic [DATA_SIZE-1:0] SOF         = 8'hA5,
  parameter int                   CHECKSUM_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_word_start,
  input  logic [TX_WIDTH-1:0]  tx_word,
  input  logic                 tx_byte_ready,
  output logic                 tx_busy,
  output logic                 tx_byte_start,
  output logic [DATA_SIZE-1:0] tx_byte
);

  localparam int TX_COUNT = ceil_div(TX_WIDTH, DATA_SIZE);
  localparam int PAD_W    = TX_COUNT * DATA_SIZE;
  localparam int CNT_W    = $clog2(TX_COUNT + 1);

  tx_state_t            state, state_n;
  tx_state_t            ret, ret_n;
  logic [PAD_W-1:0]     shift, shift_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [DATA_SIZE-1:0] sum, sum_n;
  logic                 busy_n, start_n;
  logic [DATA_SIZE-1:0] byte_n;
  logic [PAD_W-1:0]     word_pad;

  // Modulo-2^DATA_SIZE sum of all payload bytes (padding bytes are zero).
  function automatic logic [DATA_SIZE-1:0] payload_sum(input logic [PAD_W-1:0] w);
    logic [DATA_SIZE-1:0] s;
    s = '0;
    for (int i = 0; i < TX_COUNT; i++) s = s + w[i*DATA_SIZE +: DATA_SIZE];
    return s;
  endfunction

  assign word_pad = PAD_W'(tx_word);

  // Next-state and output decode; every emit detours through T_GAP, whose
  // ret register says where to resume (T_IDLE meaning the frame is done).
  always_comb begin
    state_n = state;
    ret_n   = ret;
    shift_n = shift;
    cnt_n   = cnt;
    sum_n   = sum;
    busy_n  = tx_busy;
    start_n = 1'b0;
    byte_n  = tx_byte;
    case (state)
      T_IDLE: begin
        if (tx_word_start) begin
          shift_n = word_pad;
          sum_n   = payload_sum(word_pad);
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = T_SOF;
        end
      end
      T_SOF: begin
        if (tx_byte_ready) begin
          start_n = 1'b1;
          byte_n  = SOF;
          ret_n   = T_DATA;
          state_n = T_GAP;
        end
      end
      T_DATA: begin
        if (tx_byte_ready) begin
          start_n = 1'b1;
          byte_n  = shift[PAD_W-1 -: DATA_SIZE];
          shift_n = shift << DATA_SIZE;
          cnt_n   = cnt + CNT_W'(1);
          if (cnt == CNT_W'(TX_COUNT - 1)) ret_n = (CHECKSUM_EN != 0) ? T_CHK : T_IDLE;
          else                             ret_n = T_DATA;
          state_n = T_GAP;
        end
      end
      T_CHK: begin
        if (tx_byte_ready) begin
          start_n = 1'b1;
          byte_n  = sum;
          ret_n   = T_IDLE;
          state_n = T_GAP;
        end
      end
      T_GAP: begin
        // Ready is ignored here: UART_TX only drops it the cycle after start.
        state_n = ret;
        if (ret == T_IDLE) busy_n = 1'b0;
      end
      default: state_n = T_IDLE;
    endcase
  end

  // State, datapath and registered outputs; reset aborts any frame at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= T_IDLE;
      ret           <= T_IDLE;
      shift         <= '0;
      cnt           <= '0;
      sum           <= '0;
      tx_busy       <= 1'b0;
      tx_byte_start <= 1'b0;
      tx_byte       <= '0;
    end else begin
      state         <= state_n;
      ret           <= ret_n;
      shift         <= shift_n;
      cnt           <= cnt_n;
      sum           <= sum_n;
      tx_busy       <= busy_n;
      tx_byte_start <= start_n;
      tx_byte       <= byte_n;
    end
  end

endmodule

// File: rtl/uart_frame_codec.sv
// Framed byte-stream codec: RX frame hunter/assembler with checksum and
// inter-byte timeout, plus an independent TX serializer.
module uart_frame_codec
  import uart_frame_pkg::*;
#(
  parameter int                   DATA_SIZE      = 8,
  parameter int                   TX_WIDTH       = 38,
  parameter int                   RX_WIDTH       = 65,
  parameter logic [DATA_SIZE-1:0] SOF            = 8'hA5,
  parameter int                   CHECKSUM_EN    = 1,
  parameter int                   TIMEOUT_CYCLES = 20000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_byte_valid,
  input  logic [DATA_SIZE-1:0] rx_byte,
  output logic                 rx_word_valid,
  output logic [RX_WIDTH-1:0]  rx_word,
  output logic                 rx_err,
  output logic [1:0]           rx_err_code,
  input  logic                 tx_word_start,
  input  logic [TX_WIDTH-1:0]  tx_word,
  output logic                 tx_busy,
  output logic                 tx_byte_start,
  output logic [DATA_SIZE-1:0] tx_byte,
  input  logic                 tx_byte_ready
);

  localparam int RX_COUNT = ceil_div(RX_WIDTH, DATA_SIZE);
  localparam int RX_PAD_W = RX_COUNT * DATA_SIZE;
  localparam int RX_CNT_W = $clog2(RX_COUNT + 1);
  localparam int TMR_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  rx_state_t             rx_st, rx_st_n;
  logic [RX_PAD_W-1:0]   asm_q, asm_n, asm_shift;
  logic [RX_CNT_W-1:0]   cnt, cnt_n;
  logic [DATA_SIZE-1:0]  sum, sum_n;
  logic [TMR_W-1:0]      tmr, tmr_n;
  logic [RX_WIDTH-1:0]   word_n;
  logic                  vld_n, err_n;
  logic [1:0]            code_n;
  logic                  timed_out;

  assign asm_shift = (asm_q << DATA_SIZE) | RX_PAD_W'(rx_byte);
  assign timed_out = (TIMEOUT_CYCLES != 0) && (tmr == TMR_W'(TIMEOUT_CYCLES));

  // RX next-state decode. The result strobe is issued on the edge that
  // accepts the final byte; R_DONE then hunts like R_HUNT so an SOF
  // arriving right behind a frame is not lost.
  always_comb begin
    rx_st_n = rx_st;
    asm_n   = asm_q;
    cnt_n   = cnt;
    sum_n   = sum;
    tmr_n   = tmr;
    word_n  = rx_word;
    vld_n   = 1'b0;
    err_n   = 1'b0;
    code_n  = rx_err_code;
    case (rx_st)
      R_HUNT, R_DONE: begin
        rx_st_n = R_HUNT;
        tmr_n   = '0;
        if (rx_byte_valid && (rx_byte == SOF)) begin
          rx_st_n = R_DATA;
          asm_n   = '0;
          cnt_n   = '0;
          sum_n   = '0;
        end
      end
      R_DATA: begin
        if (rx_byte_valid) begin
          tmr_n = '0;
          asm_n = asm_shift;
          sum_n = sum + rx_byte;
          cnt_n = cnt + RX_CNT_W'(1);
          if (cnt == RX_CNT_W'(RX_COUNT - 1)) begin
            if (CHECKSUM_EN != 0) begin
              rx_st_n = R_CHK;
            end else begin
              rx_st_n = R_DONE;
              vld_n   = 1'b1;
              word_n  = asm_shift[RX_WIDTH-1:0];
            end
          end
        end else if (timed_out) begin
          rx_st_n = R_HUNT;
          err_n   = 1'b1;
          code_n  = CODE_TIMEOUT;
        end else begin
          tmr_n = tmr + TMR_W'(1);
        end
      end
      R_CHK: begin
        if (rx_byte_valid) begin
          tmr_n = '0;
          if (rx_byte == sum) begin
            rx_st_n = R_DONE;
            vld_n   = 1'b1;
            word_n  = asm_q[RX_WIDTH-1:0];
          end else begin
            rx_st_n = R_HUNT;
            err_n   = 1'b1;
            code_n  = CODE_CHECKSUM;
          end
        end else if (timed_out) begin
          rx_st_n = R_HUNT;
          err_n   = 1'b1;
          code_n  = CODE_TIMEOUT;
        end else begin
          tmr_n = tmr + TMR_W'(1);
        end
      end
      default: rx_st_n = R_HUNT;
    endcase
  end

  // RX state, assembly register, timeout counter and registered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_st         <= R_HUNT;
      asm_q         <= '0;
      cnt           <= '0;
      sum           <= '0;
      tmr           <= '0;
      rx_word       <= '0;
      rx_word_valid <= 1'b0;
      rx_err        <= 1'b0;
      rx_err_code   <= 2'b00;
    end else begin
      rx_st         <= rx_st_n;
      asm_q         <= asm_n;
      cnt           <= cnt_n;
      sum           <= sum_n;
      tmr           <= tmr_n;
      rx_word       <= word_n;
      rx_word_valid <= vld_n;
      rx_err        <= err_n;
      rx_err_code   <= code_n;
    end
  end

  uart_frame_ser #(
    .DATA_SIZE   (DATA_SIZE),
    .TX_WIDTH    (TX_WIDTH),
    .SOF         (SOF),
    .CHECKSUM_EN (CHECKSUM_EN)
  ) u_ser (
    .clk           (clk),
    .rst           (rst),
    .tx_word_start (tx_word_start),
    .tx_word       (tx_word),
    .tx_byte_ready (tx_byte_ready),
    .tx_busy       (tx_busy),
    .tx_byte_start (tx_byte_start),
    .tx_byte       (tx_byte)
  );

endmodule

// File: doc/uart_frame_codec.md
# uart_frame_codec

Framed byte-stream codec between the UART_TX/UART_RX byte engines and wide-word datapath blocks such as FPMUL. The RX side hunts for a start-of-frame byte, assembles RX_WIDTH payload bits MSB-byte-first, checks an additive checksum and an inter-byte timeout, then presents one word. The TX side serializes a TX_WIDTH word into SOF, payload and checksum bytes through the UART_TX start/ready handshake. It is the parametrised successor to uart_wrapper's fixed-count packing: it adds framing, resynchronisation and error reporting.

## Interface
- DATA_SIZE, 8: UART byte width.
- TX_WIDTH, 38: outgoing word width (P plus six flags).
- RX_WIDTH, 65: incoming word width ({Start, A, B}).
- SOF, 8'hA5: start-of-frame byte.
- CHECKSUM_EN, 1: 1 appends and checks the checksum byte; 0 omits it.
- TIMEOUT_CYCLES, 20000: maximum idle clocks between bytes inside a frame; 0 disables the timeout.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_byte_valid  in  1  one-cycle strobe from UART_RX.
- rx_byte  in  DATA_SIZE  received byte.
- rx_word_valid  out  1  one-cycle strobe: rx_word is updated and good.
- rx_word  out  RX_WIDTH  last good payload, held until the next good frame.
- rx_err  out  1  one-cycle strobe: frame discarded.
- rx_err_code  out  2  01 = checksum mismatch, 10 = timeout; held until the next rx_err.
- tx_word_start  in  1  request to send tx_word.
- tx_word  in  TX_WIDTH  word to send; sampled only when the request is accepted.
- tx_busy  out  1  high from acceptance until the last byte has been handed off.
- tx_byte_start  out  1  one-cycle strobe to UART_TX.
- tx_byte  out  DATA_SIZE  byte to UART_TX; valid while tx_byte_start is high.
- tx_byte_ready  in  1  UART_TX idle.

## Operation
- Byte counts:
  - RX_COUNT = ceil(RX_WIDTH/DATA_SIZE); TX_COUNT = ceil(TX_WIDTH/DATA_SIZE).
  - Each word is zero-padded in its MSBs to a whole number of bytes. The most significant byte goes first.
- Checksum: sum modulo 2^DATA_SIZE of the payload bytes only. The SOF byte is excluded.
- RX state machine:
  - R_HUNT: non-SOF bytes are dropped silently. An SOF byte moves to R_DATA with the count and sum cleared.
  - R_DATA: each byte shifts into the assembly register. After byte RX_COUNT, go to R_CHK, or to R_DONE if CHECKSUM_EN=0.
  - R_CHK: on the next byte, go to R_DONE if it matches the sum. On a mismatch, raise rx_err with code 01 and return to R_HUNT.
  - R_DONE: load rx_word, pulse rx_word_valid, return to R_HUNT.
  - An SOF value seen inside R_DATA or R_CHK is payload. There is no escaping.
- Timeout:
  - The counter clears on every accepted byte and runs only in R_DATA and R_CHK.
  - When it reaches TIMEOUT_CYCLES with no byte that cycle: raise rx_err with code 10 and go to R_HUNT. The partial word is discarded and rx_word is unchanged.
  - A byte arriving on the expiry cycle wins; no timeout is raised.
- TX state machine:
  - T_IDLE: tx_word_start latches the word and sum and sets tx_busy. A start while busy is ignored.
  - T_SOF, T_DATA (TX_COUNT bytes), T_CHK (only when CHECKSUM_EN=1): each state emits one byte.
  - Every emit pulses tx_byte_start only on a cycle where tx_byte_ready=1, then passes through T_GAP for one cycle with ready ignored. UART_TX drops ready the cycle after start.
  - After the last emit, return to T_IDLE and clear tx_busy.
- RX and TX are fully independent. Simultaneous activity on both is legal.

## Timing
- Reset values:
  - all strobes 0; tx_busy 0; rx_word 0; rx_err_code 00; tx_byte 0;
  - both state machines in their idle/hunt state; counters and sums cleared.
- A reset mid-frame aborts both directions immediately. No partial byte strobe is issued afterwards.
- rx_word_valid and rx_err are registered. They rise 1 clock after the clock edge that accepts the final byte.
- tx_busy rises 1 clock after accepting tx_word_start.
- The first tx_byte_start is no earlier than 1 clock after acceptance.
- Consecutive tx_byte_start pulses are at least 2 clocks apart.

## Structure
- Package uart_frame_pkg holds:
  - the RX and TX state enums;
  - error-code constants CODE_CHECKSUM = 2'b01 and CODE_TIMEOUT = 2'b10;
  - the byte-count function ceil_div(width, DATA_SIZE).
- Sub-module uart_frame_ser is the TX serializer state machine. The top level holds the RX assembler and the timeout counter.

## Test plan
- RX frame, default params: A5 01 01 23 45 67 89 AB CD EF C1 -> one rx_word_valid; rx_word = 65'h1_0123_4567_89AB_CDEF.
- RX bad checksum: same frame with the final byte C2 -> rx_err, rx_err_code = 01; no rx_word_valid; rx_word unchanged.
- RX timeout with TIMEOUT_CYCLES=100:
  - A5 then 4 payload bytes, then 100 idle clocks -> rx_err, code 10.
  - A following valid frame -> accepted.
- RX resync: bytes 00 FF then a valid frame -> exactly one rx_word_valid.
- TX: tx_word = 38'h00_3F80_0000, UART_TX model ready handshake -> bytes A5 00 3F 80 00 00 BF in order.
  - tx_busy falls after BF.
  - A tx_word_start issued mid-frame produces no extra bytes.
- CHECKSUM_EN=0 loopback of TX into RX (TX_WIDTH=RX_WIDTH=65) -> rx_word equals tx_word.
- Reset asserted during the 5th TX byte -> tx_busy = 0 and no further tx_byte_start.
